// File: rtl/cache_arbiter_if.sv
// Bundle of the instruction-cache, data-cache and physical-memory signals seen by cache_arbiter.
// The master modport is the arbiter's view; slave is the caches-plus-memory view.
interface cache_arbiter_if #(
  parameter int s_line = 256
);
  logic              i_pmem_read;
  logic [31:0]       i_pmem_address;
  logic [s_line-1:0] i_pmem_rdata;
  logic              i_pmem_resp;

  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [31:0]       d_pmem_address;
  logic [s_line-1:0] d_pmem_wdata;
  logic [s_line-1:0] d_pmem_rdata;
  logic              d_pmem_resp;

  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_address;
  logic [s_line-1:0] mem_wdata;
  logic [s_line-1:0] mem_rdata;
  logic              mem_resp;

  modport master (
    input  i_pmem_read, i_pmem_address,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  mem_rdata, mem_resp,
    output i_pmem_rdata, i_pmem_resp,
    output d_pmem_rdata, d_pmem_resp,
    output mem_read, mem_write, mem_address, mem_wdata
  );

  modport slave (
    output i_pmem_read, i_pmem_address,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output mem_rdata, mem_resp,
    input  i_pmem_rdata, i_pmem_resp,
    input  d_pmem_rdata, d_pmem_resp,
    input  mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line traffic onto one physical memory port.
// Define CACHE_ARBITER_RR_EN for round-robin tie-break; otherwise D wins ties.
module cache_arbiter #(
  parameter int s_line = 256
) (
  input  logic            clk,
  input  logic            rst,
  cache_arbiter_if.master bus
);

  typedef logic [s_line-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    DONE
  } state_e;

  state_e state_q, state_d;
  logic   i_req, d_req, d_wins;
  line_t  mem_wdata_c;

`ifdef CACHE_ARBITER_RR_EN
  logic last_served_d_q, last_served_d_d;

  // On a tie, D is granted only if I was the last one served.
  assign d_wins = d_req & (~i_req | ~last_served_d_q);
`else
  assign d_wins = d_req;
`endif

  assign i_req = bus.i_pmem_read;
  assign d_req = bus.d_pmem_read | bus.d_pmem_write;

  assign bus.i_pmem_rdata = bus.mem_rdata;
  assign bus.d_pmem_rdata = bus.mem_rdata;
  assign bus.mem_wdata    = mem_wdata_c;

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d         = state_q;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_address = '0;
    mem_wdata_c     = '0;
    bus.i_pmem_resp = 1'b0;
    bus.d_pmem_resp = 1'b0;
`ifdef CACHE_ARBITER_RR_EN
    last_served_d_d = last_served_d_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (d_wins) begin
          state_d = SERVE_D;
`ifdef CACHE_ARBITER_RR_EN
          last_served_d_d = 1'b1;
`endif
        end else if (i_req) begin
          state_d = SERVE_I;
`ifdef CACHE_ARBITER_RR_EN
          last_served_d_d = 1'b0;
`endif
        end
      end

      SERVE_I: begin
        bus.mem_read    = bus.i_pmem_read;
        bus.mem_address = bus.i_pmem_address;
        if (bus.mem_resp) begin
          // A completion arriving while reset is held belongs to an aborted transfer.
          bus.i_pmem_resp = ~rst;
          state_d         = DONE;
        end
      end

      SERVE_D: begin
        bus.mem_write   = bus.d_pmem_write;
        bus.mem_read    = bus.d_pmem_read & ~bus.d_pmem_write;
        bus.mem_address = bus.d_pmem_address;
        mem_wdata_c     = bus.d_pmem_wdata;
        if (bus.mem_resp) begin
          bus.d_pmem_resp = ~rst;
          state_d         = DONE;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; reset here is synchronous and only seen at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
`ifdef CACHE_ARBITER_RR_EN
      last_served_d_q <= 1'b1;
`endif
    end else begin
      state_q         <= state_d;
`ifdef CACHE_ARBITER_RR_EN
      last_served_d_q <= last_served_d_d;
`endif
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a transaction-level ownership model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_cache_arbiter;
  localparam int S_LINE = 256;

  logic clk = 1'b0;
  logic rst;

  cache_arbiter_if #(.s_line(S_LINE)) bus ();

  cache_arbiter #(.s_line(S_LINE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [S_LINE-1:0] act,
                       input logic [S_LINE-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: who currently owns the memory port, and how many dead cycles remain
  // after a completion before a new grant may be taken.
  typedef enum {M_NONE, M_I, M_D} own_t;
  own_t owner    = M_NONE;
  int   blackout = 0;
  bit   last_d   = 1'b1;
  bit   mon_en   = 1'b0;

  function automatic own_t pick(input bit ir, input bit dr, input bit ld);
    if (ir && dr) begin
`ifdef CACHE_ARBITER_RR_EN
      return ld ? M_I : M_D;
`else
      return M_D;
`endif
    end
    if (dr) return M_D;
    if (ir) return M_I;
    return M_NONE;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      owner    <= M_NONE;
      blackout <= 0;
      last_d   <= 1'b1;
    end else if (owner != M_NONE) begin
      if (bus.mem_resp) begin
        owner    <= M_NONE;
        blackout <= 1;
      end
    end else if (blackout > 0) begin
      blackout <= blackout - 1;
    end else if (pick(bus.i_pmem_read, bus.d_pmem_read | bus.d_pmem_write, last_d) != M_NONE) begin
      owner  <= pick(bus.i_pmem_read, bus.d_pmem_read | bus.d_pmem_write, last_d);
      last_d <= (pick(bus.i_pmem_read, bus.d_pmem_read | bus.d_pmem_write, last_d) == M_D);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_i_rdata", bus.i_pmem_rdata, bus.mem_rdata);
      check("mon_d_rdata", bus.d_pmem_rdata, bus.mem_rdata);
      case (owner)
        M_I: begin
          check("mon_mem_read",  bus.mem_read, bus.i_pmem_read);
          check("mon_mem_write", bus.mem_write, 1'b0);
          check("mon_mem_addr",  bus.mem_address, bus.i_pmem_address);
          check("mon_mem_wdata", bus.mem_wdata, '0);
          check("mon_i_resp",    bus.i_pmem_resp, bus.mem_resp & ~rst);
          check("mon_d_resp",    bus.d_pmem_resp, 1'b0);
        end
        M_D: begin
          check("mon_mem_read",  bus.mem_read, bus.d_pmem_read & ~bus.d_pmem_write);
          check("mon_mem_write", bus.mem_write, bus.d_pmem_write);
          check("mon_mem_addr",  bus.mem_address, bus.d_pmem_address);
          check("mon_mem_wdata", bus.mem_wdata, bus.d_pmem_wdata);
          check("mon_i_resp",    bus.i_pmem_resp, 1'b0);
          check("mon_d_resp",    bus.d_pmem_resp, bus.mem_resp & ~rst);
        end
        default: begin
          check("mon_mem_read",  bus.mem_read, 1'b0);
          check("mon_mem_write", bus.mem_write, 1'b0);
          check("mon_mem_addr",  bus.mem_address, '0);
          check("mon_mem_wdata", bus.mem_wdata, '0);
          check("mon_i_resp",    bus.i_pmem_resp, 1'b0);
          check("mon_d_resp",    bus.d_pmem_resp, 1'b0);
        end
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse mem_resp in the current SERVE cycle, then drop the served request in DONE.
  task automatic serve_and_drop(input bit drop_i);
    bus.mem_resp = 1'b1;
    step();
    bus.mem_resp = 1'b0;
    if (drop_i) bus.i_pmem_read = 1'b0;
    else begin
      bus.d_pmem_read  = 1'b0;
      bus.d_pmem_write = 1'b0;
    end
    step();
  endtask

  // Wait (bounded) for a memory strobe; returns the number of edges waited.
  task automatic wait_strobe(input string name, input int budget, output int waited);
    waited = 0;
    while (!(bus.mem_read || bus.mem_write) && waited < budget) begin
      step();
      waited++;
    end
    if (!(bus.mem_read || bus.mem_write)) check({name, "_timeout"}, 1'b0, 1'b1);
  endtask

  int n;

  initial begin
    rst                = 1'b1;
    bus.i_pmem_read    = 1'b0;
    bus.i_pmem_address = '0;
    bus.d_pmem_read    = 1'b0;
    bus.d_pmem_write   = 1'b0;
    bus.d_pmem_address = '0;
    bus.d_pmem_wdata   = '0;
    bus.mem_rdata      = '0;
    bus.mem_resp       = 1'b0;

    step();
    mon_en = 1'b1;
    step();
    check("rst_mem_read",  bus.mem_read, 1'b0);
    check("rst_mem_write", bus.mem_write, 1'b0);
    check("rst_mem_addr",  bus.mem_address, '0);
    check("rst_mem_wdata", bus.mem_wdata, '0);
    check("rst_i_resp",    bus.i_pmem_resp, 1'b0);
    check("rst_d_resp",    bus.d_pmem_resp, 1'b0);
    rst = 1'b0;
    step();

    // Lone I read, completion on the third SERVE_I cycle.
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 32'h0000_0060;
    #1 check("i_idle_strobe", bus.mem_read, 1'b0);
    wait_strobe("i_latency", 4, n);
    check("i_latency_cycles", n, 1);
    check("i_mem_read", bus.mem_read, 1'b1);
    check("i_mem_addr", bus.mem_address, 32'h60);
    step();
    step();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = {32{8'hA5}};
    #1;
    check("i_resp",  bus.i_pmem_resp, 1'b1);
    check("i_rdata", bus.i_pmem_rdata, {32{8'hA5}});
    check("i_d_resp_quiet", bus.d_pmem_resp, 1'b0);
    step();
    bus.mem_resp    = 1'b0;
    bus.i_pmem_read = 1'b0;
    #1;
    check("i_done_read", bus.mem_read, 1'b0);
    check("i_done_resp", bus.i_pmem_resp, 1'b0);
    step();

    // Lone D write-back, completion on the second SERVE_D cycle.
    bus.d_pmem_write   = 1'b1;
    bus.d_pmem_address = 32'h0000_1F20;
    bus.d_pmem_wdata   = {8{32'h1234_5678}};
    step();
    check("dw_mem_write", bus.mem_write, 1'b1);
    check("dw_mem_read",  bus.mem_read, 1'b0);
    check("dw_mem_addr",  bus.mem_address, 32'h1F20);
    check("dw_mem_wdata", bus.mem_wdata, {8{32'h1234_5678}});
    step();
    bus.mem_resp = 1'b1;
    #1 check("dw_resp", bus.d_pmem_resp, 1'b1);
    step();
    bus.mem_resp     = 1'b0;
    bus.d_pmem_write = 1'b0;
    #1;
    check("dw_done_write", bus.mem_write, 1'b0);
    check("dw_done_read",  bus.mem_read, 1'b0);
    check("dw_done_wdata", bus.mem_wdata, '0);
    step();

    // Simultaneous I and D reads.
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 32'h0000_0100;
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_address = 32'h0000_0200;
    step();
`ifdef CACHE_ARBITER_RR_EN
    check("tie1_first", bus.mem_address, 32'h100);
    serve_and_drop(1'b1);
    check("tie1_gap", bus.mem_read, 1'b0);
    step();
    check("tie1_second", bus.mem_address, 32'h200);
    serve_and_drop(1'b0);
`else
    check("tie1_first", bus.mem_address, 32'h200);
    serve_and_drop(1'b0);
    check("tie1_gap", bus.mem_read, 1'b0);
    step();
    check("tie1_second", bus.mem_address, 32'h100);
    serve_and_drop(1'b1);
`endif
    bus.i_pmem_read = 1'b1;
    bus.d_pmem_read = 1'b1;
    step();
`ifdef CACHE_ARBITER_RR_EN
    check("tie2_first", bus.mem_address, 32'h100);
    serve_and_drop(1'b1);
    step();
    serve_and_drop(1'b0);
`else
    check("tie2_first", bus.mem_address, 32'h200);
    serve_and_drop(1'b0);
    step();
    serve_and_drop(1'b1);
`endif

    // Stray mem_resp in IDLE, then in DONE.
    bus.mem_resp = 1'b1;
    #1;
    check("stray_idle_i", bus.i_pmem_resp, 1'b0);
    check("stray_idle_d", bus.d_pmem_resp, 1'b0);
    step();
    check("stray_idle_stay", bus.mem_read, 1'b0);
    bus.mem_resp       = 1'b0;
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 32'h0000_0040;
    step();
    bus.mem_resp = 1'b1;
    step();
    bus.i_pmem_read = 1'b0;
    #1;
    check("stray_done_i", bus.i_pmem_resp, 1'b0);
    check("stray_done_read", bus.mem_read, 1'b0);
    step();
    bus.mem_resp = 1'b0;
    #1 check("stray_after_done", bus.mem_read, 1'b0);
    step();

    // Reset during SERVE_D with a completion arriving in the reset cycle.
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_address = 32'h0000_0300;
    step();
    check("rstd_read", bus.mem_read, 1'b1);
    step();
    rst          = 1'b1;
    bus.mem_resp = 1'b1;
    #1 check("rstd_no_resp", bus.d_pmem_resp, 1'b0);
    step();
    rst          = 1'b0;
    bus.mem_resp = 1'b0;
    #1;
    check("rstd_idle_read", bus.mem_read, 1'b0);
    check("rstd_idle_addr", bus.mem_address, '0);
    step();
    check("rstd_again_read", bus.mem_read, 1'b1);
    check("rstd_again_addr", bus.mem_address, 32'h300);
    bus.mem_resp = 1'b1;
    #1 check("rstd_again_resp", bus.d_pmem_resp, 1'b1);
    bus.mem_resp = 1'b0;
    serve_and_drop(1'b0);

    // Read and write both asserted: write takes precedence.
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_write   = 1'b1;
    bus.d_pmem_address = 32'h0000_0400;
    bus.d_pmem_wdata   = {8{32'hDEAD_BEEF}};
    step();
    check("rw_mem_write", bus.mem_write, 1'b1);
    check("rw_mem_read",  bus.mem_read, 1'b0);
    serve_and_drop(1'b0);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
